// File: rtl/vector_load_unit.sv
// Vector load stage: gathers WIDTH words from data memory, then writes one RF vector.
// Optional strided addressing is enabled by defining VLU_STRIDE_EN.
module vector_load_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
`ifdef VLU_STRIDE_EN
    input  logic [ADDR_W-1:0]           stride,
`endif
    input  logic [4:0]                  vd,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [WIDTH-1:0]            mem_rdata,
    output logic                        wev,
    output logic [4:0]                  rd,
    output logic [WIDTH-1:0][WIDTH-1:0] wd
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [IW-1:0]               r_idx;
    logic [ADDR_W-1:0]           r_addr;
    logic [ADDR_W-1:0]           w_stride;
    logic [4:0]                  r_vd;
    logic [WIDTH-1:0][WIDTH-1:0] r_buf;
    logic                        w_last;

`ifdef VLU_STRIDE_EN
    logic [ADDR_W-1:0]           r_stride;
    assign w_stride = r_stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    assign w_last = (r_idx == IW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_REQ;
            S_REQ:   if (mem_gnt) w_next = S_WAIT;
            S_WAIT:  if (mem_rvalid) w_next = w_last ? S_WRITE : S_REQ;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Buffer is only written on accepted read data; it doubles as the wd output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_addr <= '0;
            r_vd   <= '0;
            r_buf  <= '0;
`ifdef VLU_STRIDE_EN
            r_stride <= '0;
`endif
        end else if (r_state == S_IDLE && start) begin
            r_idx  <= '0;
            r_addr <= base_addr;
            r_vd   <= vd;
`ifdef VLU_STRIDE_EN
            r_stride <= stride;
`endif
        end else if (r_state == S_WAIT && mem_rvalid) begin
            r_buf[r_idx] <= mem_rdata;
            if (!w_last) begin
                r_idx  <= r_idx + 1'b1;
                r_addr <= r_addr + w_stride;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign mem_req  = (r_state == S_REQ);
    assign wev      = (r_state == S_WRITE);
    assign done     = wev;
    assign mem_addr = r_addr;
    assign rd       = r_vd;
    assign wd       = r_buf;

endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit with a stall-configurable memory responder.
// Strided cases run only when VLU_STRIDE_EN is defined.
module tb_vector_load_unit;

    localparam int W    = 16;
    localparam int AW   = 16;
    localparam int LAT0 = 2 * W + 1;

    typedef logic [W-1:0][W-1:0] vec_t;
    typedef struct {
        logic [4:0] rd;
        vec_t       wd;
        int         scyc;
        int         lat;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [4:0]    vd;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [W-1:0]  mem_rdata;
    logic          wev;
    logic [4:0]    rd;
    vec_t          wd;

    vector_load_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
`ifdef VLU_STRIDE_EN
        .stride     (stride),
`endif
        .vd         (vd),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wev        (wev),
        .rd         (rd),
        .wd         (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            n_chk;
    int            n_fail;
    int            cyc;
    int            rl;
    int            gcnt;
    int            rcnt;
    int            wev_cnt;
    int            last_wev_cyc;
    int            gnt_stall[W];
    int            rv_stall[W];
    bit            spur;
    bit            idle_chk;
    logic [AW-1:0] gaddr;

    function automatic logic [W-1:0] memval(input logic [AW-1:0] a);
        return a ^ 16'h1100;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at negedge, check, then drive responder inputs.
    task automatic cyc_step();
        @(negedge clk);
        cyc++;
        if (idle_chk) begin
            chk("busy_after", busy, 0);
            idle_chk = 0;
        end
        if (wev) begin
            wev_cnt++;
            last_wev_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("wev_extra", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd", rd, e.rd);
                chk("wd", wd, e.wd);
                chk("done", done, 1);
                chk("latency", cyc - e.scyc, e.lat);
                idle_chk = 1;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (mem_req) begin
            if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 16'hDEAD;
            end
            if (addr_q.size() == 0) begin
                chk("req_extra", 1, 0);
            end else begin
                chk("addr", mem_addr, addr_q[0]);
                if (rl < W && gcnt < gnt_stall[rl]) begin
                    gcnt++;
                end else begin
                    mem_gnt = 1'b1;
                    gaddr   = addr_q.pop_front();
                    gcnt    = 0;
                end
            end
        end else if (busy && !wev) begin
            if (rl < W && rcnt < rv_stall[rl]) begin
                rcnt++;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = memval(gaddr);
                rcnt       = 0;
                rl++;
            end
        end
    endtask

    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] s,
                          input logic [4:0] v);
        exp_t          e;
        logic [AW-1:0] a;
        logic [AW-1:0] se;
        int            extra;
`ifdef VLU_STRIDE_EN
        se = s;
`else
        se = 16'd1;
`endif
        a     = b;
        extra = 0;
        for (int i = 0; i < W; i++) begin
            addr_q.push_back(a);
            e.wd[i] = memval(a);
            a       = a + se;
            extra   = extra + gnt_stall[i] + rv_stall[i];
        end
        e.rd   = v;
        e.scyc = cyc;
        e.lat  = LAT0 + extra;
        exp_q.push_back(e);
        rl        = 0;
        gcnt      = 0;
        rcnt      = 0;
        start     = 1'b1;
        base_addr = b;
        stride    = s;
        vd        = v;
        cyc_step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            cyc_step();
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < W; i++) begin
            gnt_stall[i] = 0;
            rv_stall[i]  = 0;
        end
        spur = 0;
    endtask

    initial begin
        int w0;
        int wa;
        n_chk = 0; n_fail = 0; cyc = 0; rl = 0; gcnt = 0; rcnt = 0;
        wev_cnt = 0; last_wev_cyc = 0; idle_chk = 0; gaddr = '0;
        clear_stalls();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; stride = 16'd1; vd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cyc_step();
        cyc_step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wev", wev, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wd", wd, 0);
        rst_n = 1'b1;
        cyc_step();

        // unit stride, immediate memory
        launch(16'h0100, 16'd1, 5'd5);
        wait_done();

        // gnt stall on lane 4, rvalid delay on lane 9
        gnt_stall[4] = 3;
        rv_stall[9]  = 2;
        launch(16'h0100, 16'd1, 5'd5);
        wait_done();
        clear_stalls();

        // address wrap-around
        w0 = wev_cnt;
        launch(16'hFFF8, 16'd1, 5'd12);
        wait_done();
        chk("wrap_wevs", wev_cnt - w0, 1);

`ifdef VLU_STRIDE_EN
        launch(16'h0200, 16'd4, 5'd3);
        wait_done();
        launch(16'h0200, 16'd0, 5'd4);
        wait_done();
`endif

        // reset during lane 7 WAIT
        launch(16'h0300, 16'd1, 5'd7);
        for (int k = 0; k < 200; k++) begin
            cyc_step();
            if (busy && !mem_req && !wev && rl == 8) break;
        end
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wev", wev, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_wd", wd, 0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_q.delete();
        addr_q.delete();
        cyc_step();
        cyc_step();
        rst_n = 1'b1;
        w0 = wev_cnt;
        for (int k = 0; k < 5; k++) cyc_step();
        chk("no_wev_after_abort", wev_cnt - w0, 0);
        launch(16'h0100, 16'd1, 5'd5);
        wait_done();

        // start while busy and rvalid during REQ are ignored
        gnt_stall[3] = 2;
        spur = 1;
        w0 = wev_cnt;
        launch(16'h0400, 16'd1, 5'd8);
        for (int k = 0; k < 5; k++) cyc_step();
        start = 1'b1; base_addr = 16'h0500; vd = 5'd9;
        cyc_step();
        start = 1'b0;
        wait_done();
        for (int k = 0; k < 3; k++) cyc_step();
        chk("busy_start_wevs", wev_cnt - w0, 1);
        clear_stalls();

        // back-to-back loads
        launch(16'h0100, 16'd1, 5'd5);
        for (int k = 0; k < 200; k++) begin
            cyc_step();
            if (wev) break;
        end
        wa = last_wev_cyc;
        cyc_step();
        launch(16'h0140, 16'd1, 5'd6);
        wait_done();
        chk("b2b_gap", last_wev_cyc - wa, 34);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
